// File: rtl/adc_stream_pkg.sv
// rtl/adc_stream_pkg.sv - shared types, header layout and constants for the ADC stream packer
//
// Purpose: FSM state type, packet header bit positions, the saturation
// constant for the overflow counter, the default header ID and a helper that
// assembles the header word.
// Ports: none (package).

package adc_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        TS,
        DATA,
        WAIT
    } state_t;

    // Header word layout
    localparam int HDR_ID_LSB  = 56;  // [63:56] packet ID
    localparam int HDR_K_LSB   = 52;  // [55:52] active slots
    localparam int HDR_N_LSB   = 32;  // [47:32] events per packet
    localparam int HDR_DIV_LSB = 16;  // [31:16] rate divider
    localparam int HDR_SEQ_LSB = 0;   // [15:0]  sequence number

    localparam logic [15:0] SAT16          = 16'hFFFF;
    localparam logic [7:0]  DEFAULT_PKT_ID = 8'hF1;

    function automatic logic [63:0] build_header(
        input logic [7:0]  id,
        input logic [3:0]  k,
        input logic [15:0] n,
        input logic [6:0]  div,
        input logic [15:0] seq
    );
        logic [63:0] h;
        h = '0;
        h[HDR_ID_LSB  +: 8]  = id;
        h[HDR_K_LSB   +: 4]  = k;
        h[HDR_N_LSB   +: 16] = n;
        h[HDR_DIV_LSB +: 16] = {9'd0, div};
        h[HDR_SEQ_LSB +: 16] = seq;
        return h;
    endfunction

endpackage

// File: rtl/adc_stream_decim.sv
// rtl/adc_stream_decim.sv - runtime rate divider with enable gating for ADC conversion strobes
//
// Purpose: keeps one of every (rate_div+1) in_valid pulses while ena is high.
// The count sits at 0 whenever ena is low, so the first pulse after enable
// is always taken.
// Ports:
//   clk, rst       clock, async active-high reset
//   ena            streaming enable
//   in_valid       ADC conversion strobe
//   rate_div       divider value reloaded after each kept pulse
//   event_strobe   one-cycle strobe, coincident with the kept in_valid pulse

module adc_stream_decim
    import adc_stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       in_valid,
    input  logic [6:0] rate_div,
    output logic       event_strobe
);

    logic [6:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!ena) begin
            count <= '0;
        end else if (in_valid) begin
            count <= (count == 7'd0) ? rate_div : count - 7'd1;
        end
    end

    // Combinational so the packer can capture the samples on the same edge.
    assign event_strobe = ena && in_valid && (count == 7'd0);

endmodule

// File: rtl/adc_stream_packer.sv
// rtl/adc_stream_packer.sv - packs decimated, sign-extended ADC samples into headed 64-bit stream packets
//
// Purpose: selects K of NUM_CH channels, decimates conversions, and emits
// packets of header, timestamp and N events of ceil(K/2) data words each.
// Events that arrive while the single event buffer is occupied are dropped
// and counted.
// Ports:
//   clk, rst             clock, async active-high reset
//   ena, block           streaming enable, packet-start inhibit (level)
//   ch_sel               channel index per slot (NUM_SEL x CH_W)
//   num_sel              active slot count K (clamped to 1..NUM_SEL)
//   rate_div             keep 1 of (rate_div+1) conversions
//   num_samples          events per packet N (0 treated as 1)
//   in_valid/in_data/in_ts  ADC strobe, samples, conversion timestamp
//   m_tdata/m_tvalid/m_tready/m_tfirst/m_tlast  output stream
//   busy                 packet in progress
//   overflow_count       saturating count of dropped events

module adc_stream_packer
    import adc_stream_pkg::*;
#(
    parameter int          NUM_CH   = 16,
    parameter int          SAMPLE_W = 18,
    parameter int          NUM_SEL  = 4,
    parameter logic [7:0]  PKT_ID   = DEFAULT_PKT_ID,
    parameter int          CH_W     = $clog2(NUM_CH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          block,
    input  logic [NUM_SEL*CH_W-1:0]       ch_sel,
    input  logic [$clog2(NUM_SEL+1)-1:0]  num_sel,
    input  logic [6:0]                    rate_div,
    input  logic [15:0]                   num_samples,
    input  logic                          in_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]    in_data,
    input  logic [63:0]                   in_ts,
    output logic [63:0]                   m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tfirst,
    output logic                          m_tlast,
    output logic                          busy,
    output logic [15:0]                   overflow_count
);

    localparam int KW   = $clog2(NUM_SEL + 1);
    localparam int NW   = (NUM_SEL + 1) / 2;           // max words per event
    localparam int WI_W = (NW > 1) ? $clog2(NW) : 1;

    state_t                   state;
    logic [KW-1:0]            k_q;
    logic [15:0]              n_q;
    logic [6:0]               div_q;
    logic [NUM_SEL*CH_W-1:0]  sel_q;
    logic [WI_W-1:0]          wlast_q;     // index of the last word of an event
    logic [WI_W-1:0]          word_idx;
    logic [15:0]              ev_idx;      // event currently in the buffer
    logic [15:0]              seq;
    logic [63:0]              ts_q;
    logic [NW*64-1:0]         buf_q;

    logic [KW-1:0]            k_live;
    logic [KW-1:0]            k_m1;
    logic [KW-1:0]            k_eff;
    logic [WI_W-1:0]          wlast_live;
    logic [15:0]              n_live;
    logic [6:0]               div_eff;
    logic [NUM_SEL*CH_W-1:0]  sel_eff;
    logic [CH_W-1:0]          slot_ch;
    logic [SAMPLE_W-1:0]      slot_smp;
    logic [NW*64-1:0]         cap;
    logic [WI_W-1:0]          idx_next;
    logic [63:0]              buf_next;
    logic [63:0]              header;
    logic                     ev;
    logic                     is_idle;
    logic                     last_word;
    logic                     last_event;
    logic                     next_is_last;
    logic                     free_buf;
    logic                     drop;

    // Configuration is live while idle and frozen for the rest of a packet.
    assign is_idle = (state == IDLE);

    always_comb begin
        if (num_sel == '0) begin
            k_live = KW'(1);
        end else if (num_sel > KW'(NUM_SEL)) begin
            k_live = KW'(NUM_SEL);
        end else begin
            k_live = num_sel;
        end
    end

    assign k_m1       = k_live - KW'(1);
    assign wlast_live = WI_W'(k_m1 >> 1);
    assign n_live     = (num_samples == 16'd0) ? 16'd1 : num_samples;
    assign k_eff      = is_idle ? k_live   : k_q;
    assign div_eff    = is_idle ? rate_div : div_q;
    assign sel_eff    = is_idle ? ch_sel   : sel_q;
    assign header     = build_header(PKT_ID, 4'(k_live), n_live, rate_div, seq);

    adc_stream_decim u_decim (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .in_valid     (in_valid),
        .rate_div     (div_eff),
        .event_strobe (ev)
    );

    // Sign-extend the selected samples; unused slots stay 0, which also
    // zeroes the upper half of the last word for odd K.
    always_comb begin
        cap      = '0;
        slot_ch  = '0;
        slot_smp = '0;
        for (int s = 0; s < NUM_SEL; s++) begin
            slot_ch  = sel_eff[s*CH_W +: CH_W];
            slot_smp = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (slot_ch == CH_W'(c)) begin
                    slot_smp = in_data[c*SAMPLE_W +: SAMPLE_W];
                end
            end
            if (s < int'(k_eff)) begin
                cap[s*32 +: 32] = 32'($signed(slot_smp));
            end
        end
    end

    assign idx_next = word_idx + WI_W'(1);

    always_comb begin
        buf_next = '0;
        for (int w = 0; w < NW; w++) begin
            if (idx_next == WI_W'(w)) begin
                buf_next = buf_q[w*64 +: 64];
            end
        end
    end

    assign last_word    = (word_idx == wlast_q);
    assign last_event   = (ev_idx == n_q - 16'd1);
    assign next_is_last = ((ev_idx + 16'd1) == (n_q - 16'd1));
    assign free_buf     = (state == DATA) && m_tready && last_word;

    // An event on the cycle the buffer frees is never an overflow; after the
    // final word of a packet it is simply ignored like any event in IDLE
    // would be on a busy cycle.
    assign drop = ev && ((state == HEADER) || (state == TS) ||
                         ((state == DATA) && !free_buf));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tfirst <= 1'b0;
            m_tlast  <= 1'b0;
            busy     <= 1'b0;
            k_q      <= '0;
            n_q      <= '0;
            div_q    <= '0;
            sel_q    <= '0;
            wlast_q  <= '0;
            word_idx <= '0;
            ev_idx   <= '0;
            seq      <= '0;
            ts_q     <= '0;
            buf_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev && !block) begin
                        k_q      <= k_live;
                        n_q      <= n_live;
                        div_q    <= rate_div;
                        sel_q    <= ch_sel;
                        wlast_q  <= wlast_live;
                        buf_q    <= cap;
                        ts_q     <= in_ts;
                        word_idx <= '0;
                        ev_idx   <= '0;
                        m_tdata  <= header;
                        m_tvalid <= 1'b1;
                        m_tfirst <= 1'b1;
                        m_tlast  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= HEADER;
                    end
                end
                HEADER: begin
                    if (m_tready) begin
                        m_tdata  <= ts_q;
                        m_tfirst <= 1'b0;
                        state    <= TS;
                    end
                end
                TS: begin
                    if (m_tready) begin
                        m_tdata  <= buf_q[63:0];
                        m_tlast  <= (n_q == 16'd1) && (wlast_q == '0);
                        word_idx <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (m_tready) begin
                        if (!last_word) begin
                            word_idx <= idx_next;
                            m_tdata  <= buf_next;
                            m_tlast  <= last_event && (idx_next == wlast_q);
                        end else if (last_event) begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            busy     <= 1'b0;
                            seq      <= seq + 16'd1;
                            state    <= IDLE;
                        end else if (ev) begin
                            // Buffer frees and refills on the same edge: no bubble.
                            buf_q    <= cap;
                            ev_idx   <= ev_idx + 16'd1;
                            word_idx <= '0;
                            m_tdata  <= cap[63:0];
                            m_tlast  <= next_is_last && (wlast_q == '0);
                        end else begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (ev) begin
                        buf_q    <= cap;
                        ev_idx   <= ev_idx + 16'd1;
                        word_idx <= '0;
                        m_tdata  <= cap[63:0];
                        m_tvalid <= 1'b1;
                        m_tlast  <= next_is_last && (wlast_q == '0);
                        state    <= DATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_count <= '0;
        end else if (drop && (overflow_count != SAT16)) begin
            overflow_count <= overflow_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_adc_stream_packer.sv
// tb/tb_adc_stream_packer.sv - directed self-checking bench for adc_stream_packer

module tb_adc_stream_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         block;
    logic [15:0]  ch_sel;
    logic [2:0]   num_sel;
    logic [6:0]   rate_div;
    logic [15:0]  num_samples;
    logic         in_valid;
    logic [287:0] in_data;
    logic [63:0]  in_ts;
    logic [63:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tfirst;
    logic         m_tlast;
    logic         busy;
    logic [15:0]  overflow_count;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_cyc = 0;

    typedef struct {
        logic [63:0] data;
        logic        first;
        logic        last;
        int          cyc;
    } word_t;

    word_t q[$];

    adc_stream_packer dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .block          (block),
        .ch_sel         (ch_sel),
        .num_sel        (num_sel),
        .rate_div       (rate_div),
        .num_samples    (num_samples),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ts          (in_ts),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tfirst       (m_tfirst),
        .m_tlast        (m_tlast),
        .busy           (busy),
        .overflow_count (overflow_count)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            q.push_back('{m_tdata, m_tfirst, m_tlast, cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [63:0] ts);
        in_valid = 1'b1;
        in_ts    = ts;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic set_ch(input int c, input logic [17:0] v);
        in_data[c*18 +: 18] = v;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input string tag, input logic [63:0] d,
                               input logic f, input logic l, input bit nb);
        word_t w;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed no word expected %h", tag, d);
        end else begin
            w = q.pop_front();
            check({tag, ".data"}, w.data, d);
            check({tag, ".first"}, 64'(w.first), 64'(f));
            check({tag, ".last"}, 64'(w.last), 64'(l));
            if (nb) check({tag, ".gap"}, 64'(w.cyc - last_cyc), 64'd1);
            last_cyc = w.cyc;
        end
    endtask

    logic [63:0] hdr4;
    logic        stable;

    initial begin
        rst = 1'b1; ena = 1'b0; block = 1'b0; ch_sel = '0; num_sel = '0;
        rate_div = '0; num_samples = '0; in_valid = 1'b0; in_data = '0;
        in_ts = '0; m_tready = 1'b1;
        ticks(3);
        check("rst.tvalid", m_tvalid, 0);
        check("rst.tfirst", m_tfirst, 0);
        check("rst.tlast", m_tlast, 0);
        check("rst.tdata", m_tdata, 0);
        check("rst.busy", busy, 0);
        check("rst.ovf", overflow_count, 0);
        rst = 1'b0;
        tick();

        // Packet 1: K=2 (ch 0,5), N=3, rate_div=0
        ena = 1'b1; ch_sel = 16'h0050; num_sel = 3'd2; num_samples = 16'd3;
        set_ch(0, 18'h00011); set_ch(5, 18'h00055);
        pulse(64'h1111_2222_3333_4444);
        ticks(3);
        set_ch(0, 18'h20000); set_ch(5, 18'h1FFFF);
        pulse(64'h2);
        tick();
        set_ch(0, 18'h00001); set_ch(5, 18'h00002);
        pulse(64'h3);
        ticks(4);
        expect_word("p1.hdr", 64'hF120_0003_0000_0000, 1, 0, 0);
        expect_word("p1.ts",  64'h1111_2222_3333_4444, 0, 0, 1);
        expect_word("p1.d0",  64'h0000_0055_0000_0011, 0, 0, 1);
        expect_word("p1.d1",  64'h0001_FFFF_FFFE_0000, 0, 0, 0);
        expect_word("p1.d2",  64'h0000_0002_0000_0001, 0, 1, 0);
        check("p1.len", q.size(), 0);
        check("p1.busy", busy, 0);

        // Packet 2: K=3 (ch 1,2,3), N=1, odd K zero pad
        in_data = '0; ch_sel = 16'h0321; num_sel = 3'd3; num_samples = 16'd1;
        set_ch(1, 18'h00123); set_ch(2, 18'h3FF00); set_ch(3, 18'h3FFFF);
        pulse(64'h2);
        ticks(5);
        expect_word("p2.hdr", 64'hF130_0001_0000_0001, 1, 0, 0);
        expect_word("p2.ts",  64'h2, 0, 0, 1);
        expect_word("p2.d0",  64'hFFFF_FF00_0000_0123, 0, 0, 1);
        expect_word("p2.d1",  64'h0000_0000_FFFF_FFFF, 0, 1, 1);
        check("p2.len", q.size(), 0);

        // Packet 3: rate_div=3, 12 pulses, events on pulses 1, 5, 9
        in_data = '0; ch_sel = 16'h0007; num_sel = 3'd1; num_samples = 16'd3;
        rate_div = 7'd3;
        for (int p = 1; p <= 12; p++) begin
            set_ch(7, 18'(p));
            pulse(64'h100 + 64'(p));
            ticks(3);
        end
        expect_word("p3.hdr", 64'hF110_0003_0003_0002, 1, 0, 0);
        expect_word("p3.ts",  64'h101, 0, 0, 1);
        expect_word("p3.d0",  64'h0000_0000_0000_0001, 0, 0, 1);
        expect_word("p3.d1",  64'h0000_0000_0000_0005, 0, 0, 0);
        expect_word("p3.d2",  64'h0000_0000_0000_0009, 0, 1, 0);
        check("p3.len", q.size(), 0);
        check("p3.busy", busy, 0);
        check("p3.ovf", overflow_count, 0);

        // Packet 4: stall 200 cycles, 15 dropped events, config changes ignored
        rate_div = 7'd0; num_samples = 16'd2; m_tready = 1'b0;
        set_ch(7, 18'h2AAAA);
        pulse(64'hAAAA_0000_0000_0001);
        hdr4 = 64'hF110_0002_0000_0003;
        num_sel = 3'd3; num_samples = 16'd9; ch_sel = 16'h0777;
        set_ch(7, 18'h00077);
        stable = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            ticks(9);
            pulse(64'h4000 + 64'(k));
            if (m_tvalid !== 1'b1 || m_tfirst !== 1'b1 || m_tdata !== hdr4) stable = 1'b0;
        end
        ticks(50);
        check("p4.hold", stable, 1);
        check("p4.ovf", overflow_count, 16'd15);
        check("p4.stalled", q.size(), 0);
        m_tready = 1'b1;
        ticks(3);
        set_ch(7, 18'h00042);
        pulse(64'h4F);
        ticks(3);
        expect_word("p4.hdr", hdr4, 1, 0, 0);
        expect_word("p4.ts",  64'hAAAA_0000_0000_0001, 0, 0, 1);
        expect_word("p4.d0",  64'h0000_0000_FFFE_AAAA, 0, 0, 1);
        expect_word("p4.d1",  64'h0000_0000_0000_0042, 0, 1, 0);
        check("p4.len", q.size(), 0);

        // Block then ena drop during DATA
        in_data = '0; ch_sel = 16'h0321; num_sel = 3'd3; num_samples = 16'd1;
        set_ch(1, 18'd5); set_ch(2, 18'd6); set_ch(3, 18'd7);
        block = 1'b1;
        pulse(64'h50);
        ticks(3);
        check("blk.busy", busy, 0);
        check("blk.tvalid", m_tvalid, 0);
        check("blk.ovf", overflow_count, 16'd15);
        check("blk.len", q.size(), 0);
        block = 1'b0;
        ticks(2);
        check("blk.rel_busy", busy, 0);
        pulse(64'h5555);
        ticks(2);
        ena = 1'b0;
        ticks(3);
        for (int k = 0; k < 3; k++) begin
            pulse(64'h5600 + 64'(k));
            ticks(2);
        end
        expect_word("p5.hdr", 64'hF130_0001_0000_0004, 1, 0, 0);
        expect_word("p5.ts",  64'h5555, 0, 0, 1);
        expect_word("p5.d0",  64'h0000_0006_0000_0005, 0, 0, 1);
        expect_word("p5.d1",  64'h0000_0000_0000_0007, 0, 1, 1);
        check("p5.len", q.size(), 0);
        check("p5.busy", busy, 0);

        // Async reset mid-DATA, then free+event on the same edge
        ena = 1'b1; in_data = '0; ch_sel = 16'h0007; num_sel = 3'd1; num_samples = 16'd2;
        set_ch(7, 18'h00010);
        pulse(64'h60);
        ticks(2);
        m_tready = 1'b0;
        pulse(64'h61);
        check("p6.ovf_data", overflow_count, 16'd16);
        #2;
        rst = 1'b1;
        #1;
        check("arst.tvalid", m_tvalid, 0);
        check("arst.ovf", overflow_count, 0);
        check("arst.busy", busy, 0);
        check("arst.tlast", m_tlast, 0);
        tick();
        rst = 1'b0;
        expect_word("p6.hdr", 64'hF110_0002_0000_0005, 1, 0, 0);
        expect_word("p6.ts",  64'h60, 0, 0, 1);
        check("p6.len", q.size(), 0);
        m_tready = 1'b1;
        tick();
        set_ch(7, 18'h00021);
        pulse(64'h70);
        ticks(2);
        set_ch(7, 18'h00022);
        pulse(64'h71);
        ticks(4);
        expect_word("p7.hdr", 64'hF110_0002_0000_0000, 1, 0, 0);
        expect_word("p7.ts",  64'h70, 0, 0, 1);
        expect_word("p7.d0",  64'h0000_0000_0000_0021, 0, 0, 1);
        expect_word("p7.d1",  64'h0000_0000_0000_0022, 0, 1, 1);
        check("p7.len", q.size(), 0);
        check("p7.ovf", overflow_count, 0);
        check("p7.busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
